// File: rtl/sram_port_arb.sv
// Client-side arbiter in front of the board SRAM controller: buffers capture-path
// writes in a small FIFO and sequences fixed-length read bursts, never mixing the two.
module sram_port_arb #(
  parameter int WFIFO_AW     = 3,
  parameter int URGENT_LEVEL = 6
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        wr_valid,
  input  logic [20:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic        wr_ready,
  input  logic        rd_start,
  input  logic [20:0] rd_addr,
  input  logic [7:0]  rd_len,
  output logic        rd_ready,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        rd_done,
  output logic [20:0] data_w_address,
  output logic [31:0] data_w,
  output logic        data_w_we,
  output logic [20:0] data_r_address,
  output logic        data_r_req,
  input  logic [31:0] data_r,
  input  logic        data_r_empty
);

  // Handshakes: a write transfers on the rising edge where wr_valid && wr_ready;
  // a burst is requested by rd_start && rd_ready (rd_ready is high only in IDLE).
  localparam int DEPTH = 1 << WFIFO_AW;
  localparam int CW    = WFIFO_AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] URG_CNT  = CW'(URGENT_LEVEL);

  typedef enum logic [1:0] {IDLE, WRITE, RD_ISSUE, RD_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [20:0]         fifo_addr [DEPTH];
  logic [31:0]         fifo_data [DEPTH];
  logic [WFIFO_AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0]       count_q, count_d;
  logic [CW-1:0]       wcnt_q, wcnt_d;
  logic [20:0]         raddr_q, raddr_d;
  logic [8:0]          iss_q, iss_d;
  logic [8:0]          rcv_q, rcv_d;
  logic [1:0]          flush_q;
  logic                rd_valid_q, rd_done_q;
  logic [31:0]         rd_data_q;
  logic                push, pop, fifo_ne, capture;
  logic [8:0]          burst_len;

  assign fifo_ne   = (count_q != '0);
  assign wr_ready  = (count_q != FULL_CNT);
  assign push      = wr_valid && wr_ready;
  assign data_w_we = (state_q == WRITE) && fifo_ne;
  assign pop       = data_w_we;
  assign count_d   = count_q + CW'(push) - CW'(pop);

  assign data_w_address = fifo_ne ? fifo_addr[rptr_q] : '0;
  assign data_w         = fifo_ne ? fifo_data[rptr_q] : '0;

  assign rd_ready       = (state_q == IDLE);
  assign data_r_req     = (state_q == RD_ISSUE);
  assign data_r_address = raddr_q;
  assign rd_valid       = rd_valid_q;
  assign rd_done        = rd_done_q;
  assign rd_data        = rd_data_q;

  assign burst_len = (rd_len == 8'd0) ? 9'd256 : {1'b0, rd_len};
  // Words still in the controller pipe when reset hits are dropped by the flush window.
  assign capture   = !data_r_empty && (rcv_q != 9'd0) && (flush_q == 2'd0);

  always_comb begin
    state_d = state_q;
    raddr_d = raddr_q;
    iss_d   = iss_q;
    rcv_d   = capture ? rcv_q - 9'd1 : rcv_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      IDLE: begin
        if (count_q >= URG_CNT) begin
          state_d = WRITE;
          wcnt_d  = count_q;
        end else if (rd_start) begin
          state_d = RD_ISSUE;
          raddr_d = rd_addr;
          iss_d   = burst_len;
          rcv_d   = burst_len;
        end else if (fifo_ne) begin
          state_d = WRITE;
          wcnt_d  = count_q;
        end
      end
      WRITE: begin
        if (wcnt_q != '0) wcnt_d = wcnt_q - CW'(1);
        // A waiting burst may cut in once the words present at entry have gone out.
        if (count_d == '0) begin
          state_d = IDLE;
        end else if (rd_start && (wcnt_q <= CW'(1)) && (count_d < URG_CNT)) begin
          state_d = IDLE;
        end
      end
      RD_ISSUE: begin
        raddr_d = raddr_q + 21'd1;
        iss_d   = iss_q - 9'd1;
        if (iss_q == 9'd1) state_d = RD_DRAIN;
      end
      RD_DRAIN: begin
        if (rcv_d == 9'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_addr[wptr_q] <= wr_addr;
      fifo_data[wptr_q] <= wr_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      wcnt_q     <= '0;
      raddr_q    <= '0;
      iss_q      <= '0;
      rcv_q      <= '0;
      flush_q    <= 2'd3;
      rd_valid_q <= 1'b0;
      rd_done_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wcnt_q     <= wcnt_d;
      raddr_q    <= raddr_d;
      iss_q      <= iss_d;
      rcv_q      <= rcv_d;
      rd_valid_q <= capture;
      rd_done_q  <= capture && (rcv_q == 9'd1);
      if (push) wptr_q <= wptr_q + WFIFO_AW'(1);
      if (pop) rptr_q <= rptr_q + WFIFO_AW'(1);
      if (flush_q != 2'd0) flush_q <= flush_q - 2'd1;
      if (capture) rd_data_q <= data_r;
    end
  end

endmodule

// File: tb/tb_sram_port_arb.sv
// Bench for sram_port_arb: a 2-cycle SRAM controller model plus scoreboards of
// expected write-port words, read requests and returned read words.
module tb_sram_port_arb;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        wr_valid = 1'b0;
  logic [20:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        wr_ready;
  logic        rd_start = 1'b0;
  logic [20:0] rd_addr = '0;
  logic [7:0]  rd_len = '0;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_done;
  logic [20:0] data_w_address;
  logic [31:0] data_w;
  logic        data_w_we;
  logic [20:0] data_r_address;
  logic        data_r_req;
  logic [31:0] data_r;
  logic        data_r_empty;

  sram_port_arb #(.WFIFO_AW(3), .URGENT_LEVEL(6)) dut (
    .CLK(CLK), .RST(RST),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_start(rd_start), .rd_addr(rd_addr), .rd_len(rd_len), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_done(rd_done),
    .data_w_address(data_w_address), .data_w(data_w), .data_w_we(data_w_we),
    .data_r_address(data_r_address), .data_r_req(data_r_req),
    .data_r(data_r), .data_r_empty(data_r_empty)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [20:0] a);
    return {a[10:0], a} ^ 32'hC3A5_0F1E;
  endfunction

  // controller model: request in cycle t -> word visible in cycle t+2; not reset
  logic        v1 = 1'b0, v2 = 1'b0;
  logic [20:0] a1 = '0, a2 = '0;
  always @(posedge CLK) begin
    v1 <= data_r_req;
    a1 <= data_r_address;
    v2 <= v1;
    a2 <= a1;
  end
  assign data_r_empty = !v2;
  assign data_r       = v2 ? mem_word(a2) : 32'hDEAD_BEEF;

  // scoreboards
  logic [52:0] exp_w_q[$];
  logic [20:0] exp_req_q[$];
  logic [32:0] exp_rd_q[$];
  int          req_cyc_q[$];
  int          cyc = 0;
  int          we_total = 0, we_run = 0, we_last_run = 0;
  int          req_run = 0, req_last_run = 0;
  bit          wr_ready_dropped = 1'b0;
  logic [52:0] mw;
  logic [32:0] mr;
  int          rc;

  always @(negedge CLK) begin
    cyc++;
    if (!RST) begin
      check_eq("rw_collision", 32'(data_r_req & data_w_we), 32'd0);
      if (!wr_ready) wr_ready_dropped = 1'b1;
      if (data_w_we) begin
        we_total++;
        we_run++;
        check_eq("write_expected", 32'(exp_w_q.size() != 0), 32'd1);
        if (exp_w_q.size() != 0) begin
          mw = exp_w_q.pop_front();
          check_eq("w_addr", 32'(data_w_address), 32'(mw[52:32]));
          check_eq("w_data", data_w, mw[31:0]);
        end
      end else begin
        if (we_run != 0) we_last_run = we_run;
        we_run = 0;
      end
      if (data_r_req) begin
        req_run++;
        check_eq("req_expected", 32'(exp_req_q.size() != 0), 32'd1);
        if (exp_req_q.size() != 0) check_eq("r_addr", 32'(data_r_address), 32'(exp_req_q.pop_front()));
        req_cyc_q.push_back(cyc);
      end else begin
        if (req_run != 0) req_last_run = req_run;
        req_run = 0;
      end
      if (rd_valid) begin
        check_eq("rd_valid_expected", 32'(exp_rd_q.size() != 0), 32'd1);
        if (exp_rd_q.size() != 0) begin
          mr = exp_rd_q.pop_front();
          check_eq("rd_data", rd_data, mr[31:0]);
          check_eq("rd_done", 32'(rd_done), 32'(mr[32]));
        end
        if (req_cyc_q.size() != 0) begin
          rc = req_cyc_q.pop_front();
          check_eq("rd_latency", 32'(cyc), 32'(rc + 3));
        end
      end else begin
        check_eq("rd_done_without_valid", 32'(rd_done), 32'd0);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_write(input logic [20:0] a, input logic [31:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    for (int i = 0; i < 2000; i++) begin
      if (wr_ready) begin
        exp_w_q.push_back({a, d});
        tick();
        wr_valid = 1'b0;
        return;
      end
      tick();
    end
    check_eq("wr_accept_timeout", 32'(wr_ready), 32'd1);
    wr_valid = 1'b0;
  endtask

  task automatic start_read(input logic [20:0] a, input logic [7:0] len, output int we_at_accept);
    int          n;
    logic [20:0] ak;
    logic        last;
    n = (len == 8'd0) ? 256 : int'(len);
    for (int i = 0; i < 3000 && !rd_ready; i++) tick();
    check_eq("rd_ready_wait", 32'(rd_ready), 32'd1);
    for (int k = 0; k < n; k++) begin
      ak   = a + 21'(k);
      last = (k == n - 1);
      exp_req_q.push_back(ak);
      exp_rd_q.push_back({last, mem_word(ak)});
    end
    rd_start = 1'b1;
    rd_addr  = a;
    rd_len   = len;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (data_r_req) break;
    end
    check_eq("rd_accept", 32'(data_r_req), 32'd1);
    rd_start = 1'b0;
    we_at_accept = we_total;
  endtask

  task automatic wait_quiet();
    for (int i = 0; i < 5000; i++) begin
      if (exp_w_q.size() == 0 && exp_rd_q.size() == 0 && rd_ready) break;
      tick();
    end
    check_eq("quiet_timeout", 32'(exp_w_q.size() + exp_rd_q.size()), 32'd0);
    repeat (3) tick();
  endtask

  int          w1, w2, nw, dly;
  logic [20:0] ra;
  logic [7:0]  rl;

  initial begin
    // reset state
    RST = 1'b1;
    repeat (3) tick();
    check_eq("rst_wr_ready", 32'(wr_ready), 32'd1);
    check_eq("rst_rd_ready", 32'(rd_ready), 32'd1);
    check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
    check_eq("rst_rd_done", 32'(rd_done), 32'd0);
    check_eq("rst_rd_data", rd_data, 32'd0);
    check_eq("rst_we", 32'(data_w_we), 32'd0);
    check_eq("rst_req", 32'(data_r_req), 32'd0);
    check_eq("rst_w_addr", 32'(data_w_address), 32'd0);
    check_eq("rst_r_addr", 32'(data_r_address), 32'd0);
    check_eq("rst_data_w", data_w, 32'd0);
    RST = 1'b0;
    tick();

    // three buffered writes drain back-to-back
    wr_ready_dropped = 1'b0;
    for (int i = 0; i < 3; i++) do_write(21'h00010 + 21'(i), 32'hA0 + 32'(i));
    wait_quiet();
    check_eq("wr_ready_never_dropped", 32'(wr_ready_dropped), 32'd0);
    check_eq("we_run_len", 32'(we_last_run), 32'd3);

    // plain burst and address wrap
    start_read(21'h00100, 8'd4, w1);
    wait_quiet();
    check_eq("req_run_len", 32'(req_last_run), 32'd4);
    start_read(21'h1FFFFE, 8'd4, w1);
    wait_quiet();

    // six writes queued during a burst must all drain before the next burst
    fork
      start_read(21'h00300, 8'd16, w1);
      begin
        tick();
        tick();
        for (int i = 0; i < 6; i++) do_write(21'($urandom), $urandom);
      end
    join
    start_read(21'h00400, 8'd4, w2);
    check_eq("writes_before_burst", 32'(w2 - w1), 32'd6);
    wait_quiet();

    // FIFO fills while a 256-word burst blocks draining
    fork
      start_read(21'h00500, 8'd0, w1);
      begin
        tick();
        for (int i = 0; i < 8; i++) do_write(21'h00700 + 21'(i), $urandom);
        check_eq("wr_ready_full", 32'(wr_ready), 32'd0);
        do_write(21'h00708, 32'h0000_0909);
      end
    join
    wait_quiet();

    // reset two requests into an 8-word burst with a write buffered
    start_read(21'h00600, 8'd8, w1);
    wr_valid = 1'b1;
    wr_addr  = 21'h00777;
    wr_data  = 32'h7777_7777;
    tick();
    wr_valid = 1'b0;
    RST = 1'b1;
    tick();
    exp_w_q.delete();
    exp_req_q.delete();
    exp_rd_q.delete();
    req_cyc_q.delete();
    check_eq("mid_rst_req", 32'(data_r_req), 32'd0);
    check_eq("mid_rst_rd_ready", 32'(rd_ready), 32'd1);
    check_eq("mid_rst_wr_ready", 32'(wr_ready), 32'd1);
    RST = 1'b0;
    repeat (8) tick();
    check_eq("post_rst_fifo_empty", 32'(data_w_address), 32'd0);
    start_read(21'h00800, 8'd3, w1);
    wait_quiet();

    // randomized interleaving of bursts and writes
    for (int it = 0; it < 10; it++) begin
      ra  = 21'($urandom);
      rl  = 8'($urandom_range(1, 24));
      nw  = $urandom_range(0, 9);
      dly = $urandom_range(0, 4);
      fork
        begin
          repeat (dly) tick();
          start_read(ra, rl, w1);
        end
        for (int i = 0; i < nw; i++) do_write(21'($urandom), $urandom);
      join
      wait_quiet();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
